// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/LS memory arbiter: owner tags, memory request bundle, width defaults.
// Combinational helpers only; no latency, no backpressure. Build option ARB_RR_EN lives in mem_arb_grant.
package mem_arb_pkg;

  localparam int ADDR_WIDTH_DFLT = 32;
  localparam int DATA_WIDTH_DFLT = 32;
  localparam int BE_WIDTH_DFLT   = DATA_WIDTH_DFLT / 8;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_IF   = 2'd1,
    OWNER_LS   = 2'd2
  } owner_e;

  typedef struct packed {
    logic                       we;
    logic [BE_WIDTH_DFLT-1:0]   be;
    logic [ADDR_WIDTH_DFLT-1:0] addr;
    logic [DATA_WIDTH_DFLT-1:0] wdata;
  } mem_req_t;

  function automatic logic [ADDR_WIDTH_DFLT-1:0] word_addr(
    input logic [ADDR_WIDTH_DFLT-1:0] byte_addr
  );
    return {2'b00, byte_addr[ADDR_WIDTH_DFLT-1:2]};
  endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Grant decision between fetch (IF) and load/store (LS); LS priority with IF starvation guard, or round-robin with ARB_RR_EN.
// Grants are combinational from valids and state (0 cycles); a requester that is not granted simply holds valid.
module mem_arb_grant
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic arst_n,
  input  logic if_req_valid,
  input  logic if_flush,
  input  logic ls_req_valid,
  output logic if_gnt,
  output logic ls_gnt
);

  logic if_ok;
  assign if_ok = if_req_valid && !if_flush;

`ifdef ARB_RR_EN

  owner_e last_win_q, last_win_d;

  // Only genuine conflicts move the last-winner flop; uncontested grants leave it alone.
  always_comb begin
    if_gnt     = if_ok && (!ls_req_valid || (last_win_q == OWNER_LS));
    ls_gnt     = ls_req_valid && !if_gnt;
    last_win_d = last_win_q;
    if (if_ok && ls_req_valid) begin
      last_win_d = if_gnt ? OWNER_IF : OWNER_LS;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      last_win_q <= OWNER_IF;
    end else begin
      last_win_q <= last_win_d;
    end
  end

`else

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       starved;

  // Counter saturates at the limit; a flush cycle neither counts nor lets IF win.
  always_comb begin
    starved      = (starve_cnt_q >= LIMIT);
    if_gnt       = if_ok && (!ls_req_valid || starved);
    ls_gnt       = ls_req_valid && !if_gnt;
    starve_cnt_d = starve_cnt_q;
    if (!if_req_valid || if_gnt) begin
      starve_cnt_d = 4'd0;
    end else if (!if_flush && !starved) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      starve_cnt_q <= 4'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous single-port memory between IF and LS; grant policy set by ARB_RR_EN (see mem_arb_grant).
// Grant issues to memory the same cycle, response one cycle later routed by owner; losers hold valid (ready low).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DFLT,
  parameter int DATA_WIDTH   = DATA_WIDTH_DFLT,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic                    if_req_valid,
  output logic                    if_req_ready,
  input  logic [ADDR_WIDTH-1:0]   if_req_addr,
  input  logic                    if_flush,
  output logic                    if_rsp_valid,
  output logic [DATA_WIDTH-1:0]   if_rsp_data,
  input  logic                    ls_req_valid,
  output logic                    ls_req_ready,
  input  logic                    ls_req_we,
  input  logic [DATA_WIDTH/8-1:0] ls_req_be,
  input  logic [ADDR_WIDTH-1:0]   ls_req_addr,
  input  logic [DATA_WIDTH-1:0]   ls_req_wdata,
  output logic                    ls_rsp_valid,
  output logic [DATA_WIDTH-1:0]   ls_rsp_data,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  logic     if_gnt, ls_gnt;
  mem_req_t req;
  owner_e   owner_q, owner_d;
  logic     store_q, store_d;

  mem_arb_grant #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_grant (
    .clk          (clk),
    .arst_n       (arst_n),
    .if_req_valid (if_req_valid),
    .if_flush     (if_flush),
    .ls_req_valid (ls_req_valid),
    .if_gnt       (if_gnt),
    .ls_gnt       (ls_gnt)
  );

  assign if_req_ready = if_gnt;
  assign ls_req_ready = ls_gnt;

  // The request bundle is sized by the package width defaults.
  always_comb begin
    req = '0;
    if (ls_gnt) begin
      req.we    = ls_req_we;
      req.be    = ls_req_we ? ls_req_be : '1;
      req.addr  = word_addr(ls_req_addr);
      req.wdata = ls_req_we ? ls_req_wdata : '0;
    end else if (if_gnt) begin
      req.be    = '1;
      req.addr  = word_addr(if_req_addr);
    end
  end

  assign mem_req   = if_gnt || ls_gnt;
  assign mem_we    = req.we;
  assign mem_be    = req.be;
  assign mem_addr  = req.addr;
  assign mem_wdata = req.wdata;

  always_comb begin
    owner_d = OWNER_NONE;
    if (ls_gnt) begin
      owner_d = OWNER_LS;
    end else if (if_gnt) begin
      owner_d = OWNER_IF;
    end
    store_d = ls_gnt && ls_req_we;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      owner_q <= OWNER_NONE;
      store_q <= 1'b0;
    end else begin
      owner_q <= owner_d;
      store_q <= store_d;
    end
  end

  // A flush in the response cycle squashes a stale fetch; LS is never affected.
  assign if_rsp_valid = (owner_q == OWNER_IF) && !if_flush;
  assign if_rsp_data  = if_rsp_valid ? mem_rdata : '0;
  assign ls_rsp_valid = (owner_q == OWNER_LS);
  assign ls_rsp_data  = (ls_rsp_valid && !store_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against a queue-free reference model.
// Honours ARB_RR_EN when defined for the bench build as well.
module tb_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        preload = 1'b0;
  logic        if_req_valid, if_req_ready, if_flush, if_rsp_valid;
  logic [31:0] if_req_addr, if_rsp_data;
  logic        ls_req_valid, ls_req_ready, ls_req_we, ls_rsp_valid;
  logic [3:0]  ls_req_be;
  logic [31:0] ls_req_addr, ls_req_wdata, ls_rsp_data;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .arst_n(arst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_flush(if_flush), .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_we(ls_req_we),
    .ls_req_be(ls_req_be), .ls_req_addr(ls_req_addr), .ls_req_wdata(ls_req_wdata),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous single-port RAM, 256 words; garbage on rdata when idle to expose leaks.
  logic [31:0] mem_arr [256];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= 32'(i);
      mem_rdata <= '0;
    end else if (mem_req) begin
      for (int b = 0; b < 4; b++)
        if (mem_we && mem_be[b]) mem_arr[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= mem_arr[mem_addr[7:0]];
    end else begin
      mem_rdata <= 32'hDEAD_BEEF;
    end
  end

  logic [31:0] ref_mem [256];
  int          m_pend;
  bit          m_pend_store;
  logic [31:0] m_pend_data;
  int          m_starve;
  bit          m_if_next;
  bit          e_if_gnt, e_ls_gnt, e_if_rv, e_ls_rv;
  logic [31:0] e_if_rd, e_ls_rd, e_addr;
  logic [3:0]  e_be;

  task automatic drive(input bit ifv, input logic [31:0] ifa, input bit fl, input bit lsv,
                       input bit we, input logic [3:0] be, input logic [31:0] la, input logic [31:0] wd);
    if_req_valid = ifv; if_req_addr = ifa; if_flush = fl;
    ls_req_valid = lsv; ls_req_we = we; ls_req_be = be; ls_req_addr = la; ls_req_wdata = wd;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pend = 0; m_starve = 0; m_if_next = 1'b0;
  endtask

  task automatic model_eval();
    bit if_ok;
    if_ok = if_req_valid && !if_flush;
`ifdef ARB_RR_EN
    e_if_gnt = if_ok && (!ls_req_valid || m_if_next);
`else
    e_if_gnt = if_ok && (!ls_req_valid || m_starve >= LIMIT);
`endif
    e_ls_gnt = ls_req_valid && !e_if_gnt;
    e_addr   = e_ls_gnt ? (ls_req_addr >> 2) : (if_req_addr >> 2);
    e_be     = (e_ls_gnt && ls_req_we) ? ls_req_be : 4'hF;
    e_if_rv  = (m_pend == 1) && !if_flush;
    e_if_rd  = e_if_rv ? m_pend_data : 32'h0;
    e_ls_rv  = (m_pend == 2);
    e_ls_rd  = (e_ls_rv && !m_pend_store) ? m_pend_data : 32'h0;
  endtask

  task automatic model_commit();
    int idx;
    if (e_ls_gnt) begin
      idx = int'(ls_req_addr[9:2]);
      m_pend = 2; m_pend_store = ls_req_we; m_pend_data = ref_mem[idx];
      if (ls_req_we)
        for (int b = 0; b < 4; b++)
          if (ls_req_be[b]) ref_mem[idx][8*b +: 8] = ls_req_wdata[8*b +: 8];
    end else if (e_if_gnt) begin
      idx = int'(if_req_addr[9:2]);
      m_pend = 1; m_pend_data = ref_mem[idx];
    end else begin
      m_pend = 0;
    end
    if (!if_req_valid || e_if_gnt) m_starve = 0;
    else if (!if_flush) m_starve++;
    if (if_req_valid && !if_flush && ls_req_valid) m_if_next = e_ls_gnt;
  endtask

  task automatic test_reset();
    arst_n = 1'b0; preload = 1'b1; idle(); model_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'(i);
    repeat (2) @(posedge clk);
    #1 preload = 1'b0;
    @(negedge clk);
    total++;
    if ({if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid, mem_req, mem_we, mem_be,
         mem_addr, mem_wdata, if_rsp_data, ls_rsp_data} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", {if_req_ready, ls_req_ready, if_rsp_valid,
        ls_rsp_valid, mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_rsp_data, ls_rsp_data});
    end
    step();
    arst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({if_rsp_valid, ls_rsp_valid, mem_req, if_rsp_data, ls_rsp_data} !== '0) begin
      bad++; $display("FAIL post_reset_idle got=%h want=0",
                      {if_rsp_valid, ls_rsp_valid, mem_req, if_rsp_data, ls_rsp_data});
    end
    step();
  endtask

  task automatic test_if_stream();
    for (int c = 0; c < 4; c++) begin
      if (c < 3) drive(1'b1, 32'(4*c), 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      else idle();
      model_eval();
      @(negedge clk);
      total++;
      if (if_req_ready !== (c < 3)) begin
        bad++; $display("FAIL if_stream_ready c=%0d got=%b want=%b", c, if_req_ready, (c < 3));
      end
      if (c < 3) begin
        total++;
        if ({mem_req, mem_addr} !== {1'b1, 32'(c)}) begin
          bad++; $display("FAIL if_stream_issue c=%0d got=%b/%h want=1/%h", c, mem_req, mem_addr, c);
        end
      end
      if (c > 0) begin
        total++;
        if ({if_rsp_valid, if_rsp_data} !== {1'b1, 32'(c - 1)}) begin
          bad++; $display("FAIL if_stream_rsp c=%0d got=%b/%h want=1/%h", c, if_rsp_valid, if_rsp_data, c - 1);
        end
      end
      model_commit();
      step();
    end
  endtask

  task automatic test_starvation();
    bit [5:0]    pat;
    logic [31:0] ifa;
`ifdef ARB_RR_EN
    pat = 6'b101010;
`else
    pat = 6'b010000;
`endif
    ifa = 32'h100;
    for (int c = 0; c < 7; c++) begin
      if (c < 6) drive(1'b1, ifa, 1'b0, 1'b1, 1'b0, 4'h0, 32'(32'h40 + 4*c), 32'h0);
      else idle();
      model_eval();
      @(negedge clk);
      if (c < 6) begin
        total++;
        if ({if_req_ready, ls_req_ready} !== {pat[c], !pat[c]}) begin
          bad++; $display("FAIL starve_grant c=%0d got=%b%b want=%b%b", c, if_req_ready, ls_req_ready, pat[c], !pat[c]);
        end
      end
      total++;
      if ({if_rsp_valid, if_rsp_data, ls_rsp_valid, ls_rsp_data} !== {e_if_rv, e_if_rd, e_ls_rv, e_ls_rd}) begin
        bad++; $display("FAIL starve_rsp c=%0d got=%b/%h %b/%h want=%b/%h %b/%h", c, if_rsp_valid, if_rsp_data,
                        ls_rsp_valid, ls_rsp_data, e_if_rv, e_if_rd, e_ls_rv, e_ls_rd);
      end
      model_commit();
      if (e_if_gnt) ifa = ifa + 32'h4;
      step();
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    model_eval(); @(negedge clk);
    total++;
    if (if_req_ready !== 1'b1) begin bad++; $display("FAIL flush_pre_grant got=%b want=1", if_req_ready); end
    model_commit(); step();
    drive(1'b1, 32'h24, 1'b1, 1'b1, 1'b0, 4'h0, 32'h30, 32'h0);
    model_eval(); @(negedge clk);
    total++;
    if ({if_req_ready, ls_req_ready, if_rsp_valid, if_rsp_data} !== {1'b0, 1'b1, 1'b0, 32'h0}) begin
      bad++; $display("FAIL flush_kill got=%b%b%b/%h want=010/0", if_req_ready, ls_req_ready, if_rsp_valid, if_rsp_data);
    end
    model_commit(); step();
    drive(1'b1, 32'h24, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    model_eval(); @(negedge clk);
    total++;
    if ({if_req_ready, ls_rsp_valid, ls_rsp_data} !== {1'b1, 1'b1, 32'd12}) begin
      bad++; $display("FAIL flush_ls_unaffected got=%b%b/%h want=11/0000000c", if_req_ready, ls_rsp_valid, ls_rsp_data);
    end
    model_commit(); step();
    idle(); model_eval(); @(negedge clk);
    total++;
    if ({if_rsp_valid, if_rsp_data} !== {1'b1, 32'd9}) begin
      bad++; $display("FAIL flush_refetch got=%b/%h want=1/00000009", if_rsp_valid, if_rsp_data);
    end
    model_commit(); step();
  endtask

  task automatic test_store_load();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 4'b0011, 32'h10, 32'hAABBCCDD);
    model_eval(); @(negedge clk);
    total++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'b0011, 32'h4, 32'hAABBCCDD}) begin
      bad++; $display("FAIL store_issue got=%b%b/%h/%h/%h want=11/3/4/aabbccdd", mem_req, mem_we, mem_be, mem_addr, mem_wdata);
    end
    model_commit(); step();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    model_eval(); @(negedge clk);
    total++;
    if ({ls_rsp_valid, ls_rsp_data, mem_we, mem_be} !== {1'b1, 32'h0, 1'b0, 4'hF}) begin
      bad++; $display("FAIL store_ack got=%b/%h/%b/%h want=1/0/0/f", ls_rsp_valid, ls_rsp_data, mem_we, mem_be);
    end
    model_commit(); step();
    idle(); model_eval(); @(negedge clk);
    total++;
    if ({ls_rsp_valid, ls_rsp_data} !== {1'b1, 32'h0000CCDD}) begin
      bad++; $display("FAIL load_after_store got=%b/%h want=1/0000ccdd", ls_rsp_valid, ls_rsp_data);
    end
    model_commit(); step();
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    model_eval(); @(negedge clk);
    total++;
    if (ls_req_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_grant got=%b want=1", ls_req_ready); end
    model_commit(); step();
    arst_n = 1'b0; idle(); model_reset();
    @(negedge clk);
    total++;
    if ({ls_rsp_valid, ls_rsp_data, if_rsp_valid, if_rsp_data, mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== '0) begin
      bad++; $display("FAIL rst_mid_outputs got=%b/%h %b/%h %b want=0", ls_rsp_valid, ls_rsp_data,
                      if_rsp_valid, if_rsp_data, mem_req);
    end
    step();
    arst_n = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    model_eval(); @(negedge clk);
    total++;
    if (ls_req_ready !== 1'b1) begin bad++; $display("FAIL rst_restart_grant got=%b want=1", ls_req_ready); end
    model_commit(); step();
    idle(); model_eval(); @(negedge clk);
    total++;
    if ({ls_rsp_valid, ls_rsp_data} !== {1'b1, 32'h0000CCDD}) begin
      bad++; $display("FAIL rst_restart_rsp got=%b/%h want=1/0000ccdd", ls_rsp_valid, ls_rsp_data);
    end
    model_commit(); step();
  endtask

  task automatic test_random();
    bit          ifv, lsv, we, fl;
    logic [31:0] ifa, la, wd;
    logic [3:0]  be;
    ifv = 1'b0; lsv = 1'b0; ifa = '0; la = '0; wd = '0; be = '0; we = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (!ifv) begin
        ifv = ($urandom_range(0, 9) < 7);
        ifa = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
      end
      if (!lsv) begin
        lsv = ($urandom_range(0, 9) < 7);
        we  = 1'($urandom_range(0, 1));
        be  = 4'($urandom_range(0, 15));
        la  = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
        wd  = $urandom;
      end
      fl = ($urandom_range(0, 9) < 2);
      drive(ifv, ifa, fl, lsv, we, be, la, wd);
      model_eval();
      @(negedge clk);
      total++;
      if ({if_req_ready, ls_req_ready, mem_req} !== {e_if_gnt, e_ls_gnt, e_if_gnt || e_ls_gnt}) begin
        bad++; $display("FAIL rnd_grant n=%0d got=%b%b%b want=%b%b%b", n, if_req_ready, ls_req_ready, mem_req,
                        e_if_gnt, e_ls_gnt, e_if_gnt || e_ls_gnt);
      end
      if (e_if_gnt || e_ls_gnt) begin
        total++;
        if ({mem_addr, mem_be, mem_we} !== {e_addr, e_be, e_ls_gnt && we}) begin
          bad++; $display("FAIL rnd_issue n=%0d got=%h/%h/%b want=%h/%h/%b", n, mem_addr, mem_be, mem_we,
                          e_addr, e_be, e_ls_gnt && we);
        end
      end
      if (e_ls_gnt && we) begin
        total++;
        if (mem_wdata !== wd) begin bad++; $display("FAIL rnd_wdata n=%0d got=%h want=%h", n, mem_wdata, wd); end
      end
      total++;
      if ({if_rsp_valid, if_rsp_data} !== {e_if_rv, e_if_rd}) begin
        bad++; $display("FAIL rnd_if_rsp n=%0d got=%b/%h want=%b/%h", n, if_rsp_valid, if_rsp_data, e_if_rv, e_if_rd);
      end
      total++;
      if ({ls_rsp_valid, ls_rsp_data} !== {e_ls_rv, e_ls_rd}) begin
        bad++; $display("FAIL rnd_ls_rsp n=%0d got=%b/%h want=%b/%h", n, ls_rsp_valid, ls_rsp_data, e_ls_rv, e_ls_rd);
      end
      model_commit();
      if (e_if_gnt) ifv = 1'b0;
      if (e_ls_gnt) lsv = 1'b0;
      step();
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_if_stream();
    test_starvation();
    test_flush();
    test_store_load();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
